ocm_s2_arbiter: RTL
===================

OCM_S2_ARBITER -- requirements
Module: ocm_s2_arbiter

Interface
REQ-001 Parameter NCH, default 4: number of requesting channels, 1..16.
REQ-002 Parameter DW, default 64: data width, multiple of 8; byte-enable width BW = DW/8.
REQ-003 Parameter AW, default 14: word address width.
REQ-004 Parameter RDLAT, default 1: memory read latency in cycles, 1..4.
REQ-005 Parameter FIXED_PRI, default 0: 0 = round-robin arbitration, 1 = fixed priority with lowest index winning.
REQ-006 clk_clk  in  1  sole clock; all state updates on rising edge.
REQ-007 reset_reset_n  in  1  reset, synchronous, active-low.
REQ-008 ch_req  in  NCH  per-channel access request, level, held until granted.
REQ-009 ch_write  in  NCH  per-channel 1 = write, 0 = read.
REQ-010 ch_addr  in  NCH*AW  packed per-channel word addresses; channel i at [i*AW +: AW].
REQ-011 ch_wdata  in  NCH*DW  packed per-channel write data.
REQ-012 ch_byteenable  in  NCH*BW  packed per-channel byte enables.
REQ-013 ch_gnt  out  NCH  one-hot grant; request accepted in the cycle ch_gnt[i] is high.
REQ-014 ch_rvalid  out  NCH  one-hot read-data-valid strobe.
REQ-015 ch_rdata  out  DW  shared read data, valid for the channel flagged by ch_rvalid.
REQ-016 mem_address  out  AW; mem_chipselect  out  1; mem_write  out  1; mem_writedata  out  DW; mem_byteenable  out  BW: memory slave port command.
REQ-017 mem_clken  out  1  memory clock enable; mem_readdata  in  DW  memory read data.

Function
REQ-018 Grant is combinational from ch_req and the registered priority pointer; at most one ch_gnt bit high per cycle.
REQ-019 No grant is issued while mem_clken is 0.
REQ-020 Round-robin: search starts at pointer index and wraps from NCH-1 to 0; the first requesting channel wins.
REQ-021 Round-robin pointer updates to (granted index + 1) mod NCH on every grant and holds when there is no grant.
REQ-022 FIXED_PRI = 1: pointer is ignored; the lowest requesting index wins.
REQ-023 mem_chipselect equals OR of ch_gnt; mem_address, mem_write, mem_writedata and mem_byteenable are muxed from the granted channel.
REQ-024 With no grant, all mem_* command outputs are 0.
REQ-025 A granted read pushes a one-hot channel tag into an RDLAT-deep shift register; granted writes push an all-zero tag.
REQ-026 ch_rvalid equals the tag at the output of the shift register, exactly RDLAT cycles after the grant cycle.
REQ-027 ch_rdata is a passthrough of mem_readdata; its value is don't-care when ch_rvalid is 0.
REQ-028 Back-to-back reads, from the same or different channels, are accepted every cycle; the return order equals the grant order.
REQ-029 A write has no response; the read-after-write same-address hazard is resolved by the memory (write-first), and the arbiter adds no hazard logic.
REQ-030 If a requester drops ch_req before it is granted, the request is withdrawn and no access is issued.

Reset
REQ-031 While reset_reset_n = 0 at a clock edge, the following clear: pointer to 0, tag shift register to 0, mem_clken register to 0.
REQ-032 During reset and in the first cycle after release, ch_gnt = 0, ch_rvalid = 0, and all mem_* command outputs = 0.
REQ-033 mem_clken becomes 1 in the second cycle after release and stays 1 until the next reset.
REQ-034 Reads in flight when reset is asserted are discarded; no ch_rvalid is produced for them.

Verification
REQ-035 NCH=4, round-robin, all ch_req high from pointer 0 -> grants go 0,1,2,3,0 on five consecutive cycles.
REQ-036 FIXED_PRI=1, ch_req=4'b1010 held -> ch_gnt = 4'b0010 every cycle; channel 3 is never granted.
REQ-037 RDLAT=2: ch1 reads addr 0x005 at cycle t with memory holding 0xDEAD_BEEF at that address -> ch_rvalid = 4'b0010 at t+2 and ch_rdata = 0xDEAD_BEEF.
REQ-038 ch2 writes 0xFF...FF with byteenable 8'h0F to addr 0x3FFF, then reads it back -> low 32 bits = 0xFFFFFFFF, upper bits unchanged; no ch_rvalid for the write.
REQ-039 Reset asserted one cycle after a read grant with RDLAT=3 -> no ch_rvalid; mem_clken = 0, then 1 in the second cycle after release.
REQ-040 Alternating read/write on ch0 and ch3 for 1000 random cycles -> ch_rvalid count equals the read-grant count, and data is in grant order.

Source files
------------

// File: rtl/ocm_s2_arbiter.sv
// On-chip memory arbiter: NCH requesters share one single-port memory.
// Grant is combinational (round-robin or fixed priority). Read responses
// are steered back with a one-hot tag pipeline matched to the memory
// read latency.
module ocm_s2_arbiter #(
   parameter int NCH       = 4,
   parameter int DW        = 64,
   parameter int AW        = 14,
   parameter int RDLAT     = 1,
   parameter int FIXED_PRI = 0
) (
   input  logic                     clk_clk,
   input  logic                     reset_reset_n,
   input  logic [NCH-1:0]           ch_req,
   input  logic [NCH-1:0]           ch_write,
   input  logic [NCH*AW-1:0]        ch_addr,
   input  logic [NCH*DW-1:0]        ch_wdata,
   input  logic [NCH*(DW/8)-1:0]    ch_byteenable,
   output logic [NCH-1:0]           ch_gnt,
   output logic [NCH-1:0]           ch_rvalid,
   output logic [DW-1:0]            ch_rdata,
   output logic [AW-1:0]            mem_address,
   output logic                     mem_chipselect,
   output logic                     mem_write,
   output logic [DW-1:0]            mem_writedata,
   output logic [(DW/8)-1:0]        mem_byteenable,
   output logic                     mem_clken,
   input  logic [DW-1:0]            mem_readdata
);

   localparam int BW = DW / 8;
   localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

   logic [PW-1:0]  ptr_r;
   logic           clken_r;
   logic [NCH-1:0] tag_r [RDLAT];
   logic [NCH-1:0] gnt_s;
   logic [PW-1:0]  gnt_idx_s;
   logic           any_gnt_s;
   logic           grant_ok_s;

   // Grants are only allowed once the memory clock is enabled and reset is released.
   assign grant_ok_s = clken_r & reset_reset_n;

   // Pick the winner: search from the pointer (round-robin) or from index 0 (fixed).
   always_comb begin : grant_comb
      int  c;
      logic hit;
      any_gnt_s = 1'b0;
      gnt_idx_s = '0;
      c         = 0;
      hit       = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         if (FIXED_PRI != 0) begin
            c = k;
         end else begin
            c = int'(ptr_r) + k;
            if (c >= NCH) begin
               c = c - NCH;
            end else begin
               c = c;
            end
         end
         hit       = grant_ok_s & ~any_gnt_s & ch_req[c];
         any_gnt_s = any_gnt_s | hit;
         gnt_idx_s = hit ? PW'(c) : gnt_idx_s;
      end
      gnt_s = NCH'(any_gnt_s) << gnt_idx_s;
   end

   assign ch_gnt = gnt_s;

   // Route the granted channel's command to the memory; all-zero when idle.
   always_comb begin
      mem_chipselect = any_gnt_s;
      mem_write      = 1'b0;
      mem_address    = '0;
      mem_writedata  = '0;
      mem_byteenable = '0;
      for (int i = 0; i < NCH; i++) begin
         mem_write      = mem_write | (gnt_s[i] & ch_write[i]);
         mem_address    = mem_address    | (ch_addr[i*AW +: AW]       & {AW{gnt_s[i]}});
         mem_writedata  = mem_writedata  | (ch_wdata[i*DW +: DW]      & {DW{gnt_s[i]}});
         mem_byteenable = mem_byteenable | (ch_byteenable[i*BW +: BW] & {BW{gnt_s[i]}});
      end
   end

   // Priority pointer advances past the winner; clock enable rises one cycle after reset release.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         ptr_r   <= '0;
         clken_r <= 1'b0;
      end else begin
         clken_r <= 1'b1;
         if (any_gnt_s) begin
            ptr_r <= (gnt_idx_s == PW'(NCH - 1)) ? '0 : gnt_idx_s + PW'(1);
         end else begin
            ptr_r <= ptr_r;
         end
      end
   end

   // Read-tag pipeline: one-hot channel for reads, zero for writes, RDLAT stages deep.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         for (int k = 0; k < RDLAT; k++) begin
            tag_r[k] <= '0;
         end
      end else begin
         tag_r[0] <= gnt_s & ~ch_write;
         for (int k = 1; k < RDLAT; k++) begin
            tag_r[k] <= tag_r[k-1];
         end
      end
   end

   // Reads in flight are dropped by reset, so the strobe is also masked while reset is low.
   assign ch_rvalid = reset_reset_n ? tag_r[RDLAT-1] : '0;
   assign ch_rdata  = mem_readdata;
   assign mem_clken = clken_r;

endmodule
